float_reciprocal_iter: RTL and testbench

//  Parametrised iterative IEEE-754 reciprocal, 1/x, by Newton-Raphson on a fixed-point mantissa.

---
 rtl/float_pkg.sv | 21 ++
 rtl/fixmul_trunc.sv | 21 ++
 rtl/float_reciprocal_iter.sv | 197 +++++++++++++++++++
 tb/tb_float_reciprocal_iter.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/float_pkg.sv
// float_pkg: FSM encoding and format/seed constants shared by float_reciprocal_iter.
// Constants are functions of the format widths, returned wide and sized by the caller.
package float_pkg;
    typedef enum logic [2:0] {IDLE, LOAD, SEED, ITER_A, ITER_B, PACK, MUL, DONE} state_t;
    function automatic int bias(input int ew);
        return (1 << (ew - 1)) - 1;
    endfunction
    function automatic logic [127:0] inf_bits(input int ew, input int mw);
        return ((128'd1 << ew) - 128'd1) << mw;
    endfunction
    function automatic logic [127:0] qnan_bits(input int ew, input int mw);
        return inf_bits(ew, mw) | (128'd1 << (mw - 1));
    endfunction
    // Linear start x0 = 48/17 - 32/17*d, constants truncated to fw fraction bits
    function automatic logic [127:0] seed_c48(input int fw);
        return (128'd48 << fw) / 128'd17;
    endfunction
    function automatic logic [127:0] seed_c32(input int fw);
        return (128'd32 << fw) / 128'd17;
    endfunction
endpackage

// File: rtl/fixmul_trunc.sv
// fixmul_trunc: unsigned fixed-point multiply with FW fraction bits, truncated result.
// Output is registered, so the product appears one cycle after the operands.
module fixmul_trunc #(
    parameter int FW = 27
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [FW+1:0] a,
    input  logic [FW+1:0] b,
    output logic [FW+1:0] p
);
    logic [FW+1:0] p_d, p_q;
    always_comb begin
        p_d = (FW+2)'(({{(FW+2){1'b0}}, a} * {{(FW+2){1'b0}}, b}) >> FW);
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) p_q <= '0;
        else p_q <= p_d;
    end
    assign p = p_q;
endmodule

// File: rtl/float_reciprocal_iter.sv
// float_reciprocal_iter: iterative IEEE-754 reciprocal by Newton-Raphson on a fixed-point mantissa.
// Defining FLOAT_RECIP_DIVIDE_EN adds a dividend port and returns dividend/number instead.
module float_reciprocal_iter
    import float_pkg::*;
#(
    parameter int EXP_WIDTH  = 8,
    parameter int MANT_WIDTH = 23,
    parameter int ITERATIONS = 3,
    parameter int GUARD      = 4,
    localparam int DATA_WIDTH = 1 + EXP_WIDTH + MANT_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic [DATA_WIDTH-1:0] number,
`ifdef FLOAT_RECIP_DIVIDE_EN
    input  logic [DATA_WIDTH-1:0] dividend,
`endif
    output logic [DATA_WIDTH-1:0] output_rec,
    output logic                  ack,
    output logic                  busy
);
    localparam int EW = EXP_WIDTH;
    localparam int MW = MANT_WIDTH;
    localparam int DW = DATA_WIDTH;
    localparam int FW = MW + GUARD;
    localparam int W  = FW + 2;
    localparam int XW = EW + 2;
    localparam logic [W-1:0] C48 = W'(seed_c48(FW));
    localparam logic [W-1:0] C32 = W'(seed_c32(FW));
    localparam logic [W-1:0] ONE = W'(1) << FW;
    localparam logic [W-1:0] TWO = W'(2) << FW;
    localparam logic [DW-1:0] QNAN = DW'(qnan_bits(EW, MW));
    localparam logic [DW-1:0] INF = DW'(inf_bits(EW, MW));
    localparam logic signed [XW-1:0] BIAS = XW'(bias(EW));
    localparam logic [2:0] LAST = 3'(ITERATIONS - 1);

    state_t state_q, state_d;
    logic [DW-1:0] num_q, num_d, out_q, out_d;
    logic [W-1:0] x_q, x_d, ma, mb, p, dm, xcur;
    logic [2:0] it_q, it_d;
    logic ack_q, ack_d, busy_q, busy_d;
    logic n_sign;
    logic [EW-1:0] n_exp;
    logic [MW-1:0] n_frac;
    logic signed [XW-1:0] rexp;

    fixmul_trunc #(.FW(FW)) u_mul (.clk(clk), .reset(reset), .a(ma), .b(mb), .p(p));

    assign {n_sign, n_exp, n_frac} = num_q;
    assign dm = W'({1'b1, n_frac}) << (GUARD - 1);
    assign xcur = (it_q == '0) ? x_q : p;
    // Unflushed biased exponent of 1/number; a zero fraction is an exact power of two
    assign rexp = (BIAS <<< 1) - XW'(n_exp) - XW'(n_frac != '0);

`ifdef FLOAT_RECIP_DIVIDE_EN
    localparam logic signed [XW-1:0] EMAX = XW'((1 << EW) - 1);
    logic [DW-1:0] dv_q, dv_d, div_res, q_sign;
    logic dv_sign, n_nan, n_inf, n_zero, d_nan, d_inf, d_zero;
    logic [EW-1:0] dv_exp;
    logic [MW-1:0] dv_frac, qfrac;
    logic [W-1:0] recm, dva;
    logic signed [XW-1:0] qexp;
    assign {dv_sign, dv_exp, dv_frac} = dv_q;
    assign n_nan = (&n_exp) && n_frac != '0;
    assign n_inf = (&n_exp) && n_frac == '0;
    assign n_zero = n_exp == '0;
    assign d_nan = (&dv_exp) && dv_frac != '0;
    assign d_inf = (&dv_exp) && dv_frac == '0;
    assign d_zero = dv_exp == '0;
    assign recm = (n_frac == '0 || p < ONE) ? ONE : p;
    assign dva = W'({1'b1, dv_frac}) << GUARD;
    assign q_sign = {dv_sign ^ n_sign, {(DW-1){1'b0}}};
    assign qexp = XW'(dv_exp) + rexp - BIAS + XW'(p[W-1]);
    assign qfrac = p[W-1] ? p[FW -: MW] : p[FW-1 -: MW];
    assign div_res = (n_nan || d_nan || (n_zero && d_zero) || (n_inf && d_inf)) ? QNAN
                   : (n_zero || d_inf) ? (INF | q_sign)
                   : (d_zero || n_inf) ? q_sign
                   : (!qexp[XW-1] && qexp >= EMAX) ? (INF | q_sign)
                   : (qexp[XW-1] || qexp == '0) ? q_sign
                   : {dv_sign ^ n_sign, qexp[EW-1:0], qfrac};
`else
    logic [DW-1:0] rec_res, n_sbit;
    logic [MW-1:0] rfrac;
    logic rflush;
    assign n_sbit = {n_sign, {(DW-1){1'b0}}};
    assign rflush = rexp[XW-1] || rexp[XW-2:0] == '0;
    // Truncation can leave x a hair under 1.0 when the true value is just above it
    assign rfrac = (n_frac == '0 || p < ONE) ? '0 : p[FW-1 -: MW];
    assign rec_res = (n_exp == '0) ? (INF | n_sbit)
                   : (&n_exp) ? ((n_frac != '0) ? QNAN : n_sbit)
                   : rflush ? n_sbit
                   : {n_sign, rexp[EW-1:0], rfrac};
`endif

    always_comb begin
        state_d = state_q;
        num_d = num_q;
        x_d = x_q;
        it_d = it_q;
        out_d = out_q;
        ack_d = ack_q;
        busy_d = busy_q;
        ma = '0;
        mb = '0;
`ifdef FLOAT_RECIP_DIVIDE_EN
        dv_d = dv_q;
`endif
        case (state_q)
            IDLE: if (enable) begin
                num_d = number;
`ifdef FLOAT_RECIP_DIVIDE_EN
                dv_d = dividend;
`endif
                busy_d = 1'b1;
                state_d = LOAD;
            end
            LOAD: begin
                ma = C32;
                mb = dm;
                state_d = SEED;
            end
            SEED: begin
                x_d = C48 - p;
                it_d = '0;
                state_d = ITER_A;
            end
            ITER_A: begin
                ma = dm;
                mb = xcur;
                x_d = xcur;
                state_d = ITER_B;
            end
            ITER_B: begin
                ma = x_q;
                mb = TWO - p;
                it_d = it_q + 3'd1;
                state_d = (it_q == LAST) ? PACK : ITER_A;
            end
`ifdef FLOAT_RECIP_DIVIDE_EN
            PACK: begin
                ma = dva;
                mb = recm;
                state_d = MUL;
            end
            MUL: begin
                out_d = div_res;
                ack_d = 1'b1;
                busy_d = 1'b0;
                state_d = DONE;
            end
`else
            PACK: begin
                out_d = rec_res;
                ack_d = 1'b1;
                busy_d = 1'b0;
                state_d = DONE;
            end
`endif
            DONE: if (!enable) begin
                ack_d = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            num_q <= '0;
            x_q <= '0;
            it_q <= '0;
            out_q <= '0;
            ack_q <= 1'b0;
            busy_q <= 1'b0;
`ifdef FLOAT_RECIP_DIVIDE_EN
            dv_q <= '0;
`endif
        end else begin
            state_q <= state_d;
            num_q <= num_d;
            x_q <= x_d;
            it_q <= it_d;
            out_q <= out_d;
            ack_q <= ack_d;
            busy_q <= busy_d;
`ifdef FLOAT_RECIP_DIVIDE_EN
            dv_q <= dv_d;
`endif
        end
    end

    assign output_rec = out_q;
    assign ack = ack_q;
    assign busy = busy_q;
endmodule

// File: tb/tb_float_reciprocal_iter.sv
// tb_float_reciprocal_iter: scoreboard bench for float_reciprocal_iter, single and half precision.
// Under FLOAT_RECIP_DIVIDE_EN the dividend is held at 1.0 so reciprocal expectations still apply.
module tb_float_reciprocal_iter;
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic enable = 1'b0;
    logic h_enable = 1'b0;
    logic [31:0] number = '0;
    logic [31:0] output_rec;
    logic [15:0] h_number = '0;
    logic [15:0] h_output_rec;
    logic ack, busy, h_ack, h_busy;
    int n_cmp = 0;
    int n_bad = 0;
`ifdef FLOAT_RECIP_DIVIDE_EN
    logic [31:0] dividend = 32'h3F800000;
    logic [15:0] h_dividend = 16'h3C00;
    localparam int LAT = 10;
    localparam int H_LAT = 8;
`else
    localparam int LAT = 9;
    localparam int H_LAT = 7;
`endif
    typedef struct {
        logic [31:0] v;
        int tol;
    } exp_t;
    exp_t sb[$];

    always #5 clk = ~clk;

    float_reciprocal_iter dut (
        .clk(clk), .reset(reset), .enable(enable), .number(number),
`ifdef FLOAT_RECIP_DIVIDE_EN
        .dividend(dividend),
`endif
        .output_rec(output_rec), .ack(ack), .busy(busy)
    );

    float_reciprocal_iter #(.EXP_WIDTH(5), .MANT_WIDTH(10), .ITERATIONS(2)) dut_h (
        .clk(clk), .reset(reset), .enable(h_enable), .number(h_number),
`ifdef FLOAT_RECIP_DIVIDE_EN
        .dividend(h_dividend),
`endif
        .output_rec(h_output_rec), .ack(h_ack), .busy(h_busy)
    );

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic real sp_to_real(input logic [31:0] b);
        logic [63:0] d;
        d = {b[31], 11'(int'(b[30:23]) - 127 + 1023), b[22:0], 29'd0};
        return $bitstoreal(d);
    endfunction

    // Exact reciprocal in double precision, truncated toward zero into single precision
    function automatic logic [31:0] ref_recip(input logic [31:0] n);
        logic [63:0] d;
        int e;
        if (n[30:23] == 8'h00) return {n[31], 31'h7F800000};
        if (n[30:23] == 8'hFF) return (n[22:0] != 0) ? 32'h7FC00000 : {n[31], 31'd0};
        d = $realtobits(1.0 / sp_to_real(n));
        e = int'(d[62:52]) - 1023 + 127;
        return (e <= 0) ? {n[31], 31'd0} : {d[63], e[7:0], d[51:29]};
    endfunction

    function automatic bit ulp_ok(input logic [31:0] got, input logic [31:0] e, input int tol);
        int diff;
        if ($isunknown(got) || got[31] != e[31]) return 1'b0;
        diff = int'(got[30:0]) - int'(e[30:0]);
        return diff <= tol && diff >= -tol;
    endfunction

    task automatic issue(input logic [31:0] n, input logic [31:0] e, input int tol);
        @(negedge clk);
        number = n;
        enable = 1'b1;
        sb.push_back('{e, tol});
    endtask

    task automatic wait_ack(output int cyc, output int bc);
        cyc = 0;
        bc = 0;
        @(posedge clk);
        #1 bc += int'(busy);
        while (cyc < 40) begin
            @(posedge clk);
            #1 cyc++;
            if (ack) break;
            bc += int'(busy);
        end
    endtask

    task automatic drop();
        @(negedge clk);
        enable = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if (output_rec !== 32'h0 || ack !== 1'b0 || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_state: got rec=%h ack=%b busy=%b, want 0/0/0", output_rec, ack, busy);
        end
        n_cmp++;
        if (h_output_rec !== 16'h0 || h_ack !== 1'b0 || h_busy !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_state_half: got rec=%h ack=%b busy=%b, want 0/0/0", h_output_rec, h_ack, h_busy);
        end
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_basic();
        int cyc, bc;
        exp_t e;
        issue(32'h3EB0A3D7, ref_recip(32'h3EB0A3D7), 2);
        wait_ack(cyc, bc);
        e = sb.pop_front();
        n_cmp++;
        if (cyc !== LAT) begin
            n_bad++;
            $display("FAIL basic_latency: got %0d cycles, want %0d", cyc, LAT);
        end
        n_cmp++;
        if (bc !== LAT) begin
            n_bad++;
            $display("FAIL basic_busy_cycles: got %0d, want %0d", bc, LAT);
        end
        n_cmp++;
        if (!ulp_ok(output_rec, e.v, e.tol)) begin
            n_bad++;
            $display("FAIL basic_value: got %h, want %h +/-%0d ulp", output_rec, e.v, e.tol);
        end
        drop();
    endtask

    task automatic test_sign();
        int cyc, bc;
        exp_t e;
        logic [31:0] ops [2] = '{32'hBEFEF9DB, 32'h40000000};
        logic [31:0] exps [2] = '{ref_recip(32'hBEFEF9DB), 32'h3F000000};
        int tols [2] = '{2, 0};
        for (int i = 0; i < 2; i++) begin
            issue(ops[i], exps[i], tols[i]);
            wait_ack(cyc, bc);
            e = sb.pop_front();
            n_cmp++;
            if (!ulp_ok(output_rec, e.v, e.tol) || cyc !== LAT) begin
                n_bad++;
                $display("FAIL sign_value[%0d]: got %h after %0d cycles, want %h +/-%0d ulp after %0d", i, output_rec, cyc, e.v, e.tol, LAT);
            end
            drop();
        end
    endtask

    task automatic test_specials();
        int cyc, bc;
        exp_t e;
        logic [31:0] ops [5] = '{32'h00000000, 32'h80000000, 32'h7F800000, 32'h7FC00001, 32'h7F000000};
        logic [31:0] exps [5] = '{32'h7F800000, 32'hFF800000, 32'h00000000, 32'h7FC00000, 32'h00000000};
        for (int i = 0; i < 5; i++) begin
            issue(ops[i], exps[i], 0);
            wait_ack(cyc, bc);
            e = sb.pop_front();
            n_cmp++;
            if (output_rec !== e.v || cyc !== LAT) begin
                n_bad++;
                $display("FAIL special[%0d] %h: got %h after %0d cycles, want %h after %0d", i, ops[i], output_rec, cyc, e.v, LAT);
            end
            drop();
        end
    endtask

    task automatic test_hold();
        int cyc, bc, held;
        exp_t e;
        logic [31:0] r;
        issue(32'h3F4CCCCD, ref_recip(32'h3F4CCCCD), 2);
        wait_ack(cyc, bc);
        e = sb.pop_front();
        r = output_rec;
        n_cmp++;
        if (!ulp_ok(r, e.v, e.tol)) begin
            n_bad++;
            $display("FAIL hold_value: got %h, want %h +/-%0d ulp", r, e.v, e.tol);
        end
        held = 0;
        repeat (20) begin
            @(posedge clk);
            #1 held += int'(ack === 1'b1 && busy === 1'b0 && output_rec === r);
        end
        n_cmp++;
        if (held !== 20) begin
            n_bad++;
            $display("FAIL hold_ack: stable for %0d cycles, want 20", held);
        end
        drop();
        issue(32'h40400000, ref_recip(32'h40400000), 2);
        @(posedge clk);
        @(negedge clk);
        number = 32'h41200000;
        cyc = 0;
        while (!ack && cyc < 40) begin
            @(posedge clk);
            #1 cyc++;
            if (cyc == 3) number = 32'hC1F00000;
        end
        e = sb.pop_front();
        n_cmp++;
        if (!ulp_ok(output_rec, e.v, e.tol) || cyc !== LAT) begin
            n_bad++;
            $display("FAIL busy_number_change: got %h after %0d cycles, want %h after %0d", output_rec, cyc, e.v, LAT);
        end
        drop();
    endtask

    task automatic test_midreset();
        int cyc, bc;
        exp_t e;
        issue(32'h3F9D70A4, ref_recip(32'h3F9D70A4), 2);
        repeat (5) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        #1;
        e = sb.pop_front();
        n_cmp++;
        if (output_rec !== 32'h0 || ack !== 1'b0 || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL midreset_clear: got rec=%h ack=%b busy=%b, want 0/0/0", output_rec, ack, busy);
        end
        enable = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        issue(32'h3E800000, 32'h40800000, 0);
        wait_ack(cyc, bc);
        e = sb.pop_front();
        n_cmp++;
        if (output_rec !== e.v || cyc !== LAT) begin
            n_bad++;
            $display("FAIL midreset_next: got %h after %0d cycles, want %h after %0d", output_rec, cyc, e.v, LAT);
        end
        drop();
    endtask

    task automatic test_half();
        int cyc;
        exp_t e;
        logic [15:0] ops [2] = '{16'h3C00, 16'h4000};
        logic [15:0] exps [2] = '{16'h3C00, 16'h3800};
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            h_number = ops[i];
            h_enable = 1'b1;
            sb.push_back('{{16'h0, exps[i]}, 0});
            @(posedge clk);
            cyc = 0;
            while (cyc < 40) begin
                @(posedge clk);
                #1 cyc++;
                if (h_ack) break;
            end
            e = sb.pop_front();
            n_cmp++;
            if ({16'h0, h_output_rec} !== e.v || cyc !== H_LAT) begin
                n_bad++;
                $display("FAIL half[%0d] %h: got %h after %0d cycles, want %h after %0d", i, ops[i], h_output_rec, cyc, e.v[15:0], H_LAT);
            end
            @(negedge clk);
            h_enable = 1'b0;
            @(negedge clk);
        end
    endtask

`ifdef FLOAT_RECIP_DIVIDE_EN
    task automatic test_divide();
        int cyc, bc;
        exp_t e;
        dividend = 32'h40C00000;
        issue(32'h40400000, 32'h40000000, 1);
        wait_ack(cyc, bc);
        e = sb.pop_front();
        n_cmp++;
        if (!ulp_ok(output_rec, e.v, e.tol) || cyc !== LAT) begin
            n_bad++;
            $display("FAIL divide_6_3: got %h after %0d cycles, want %h +/-1 ulp after %0d", output_rec, cyc, e.v, LAT);
        end
        drop();
        dividend = 32'h00000000;
        issue(32'h00000000, 32'h7FC00000, 0);
        wait_ack(cyc, bc);
        e = sb.pop_front();
        n_cmp++;
        if (output_rec !== e.v) begin
            n_bad++;
            $display("FAIL divide_0_0: got %h, want %h", output_rec, e.v);
        end
        drop();
        dividend = 32'h3F800000;
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_sign();
        test_specials();
        test_hold();
        test_midreset();
        test_half();
`ifdef FLOAT_RECIP_DIVIDE_EN
        test_divide();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
